// File: rtl/fpga_mailbox_pkg.sv
// Shared types and register map for the FPGA/CPU operand mailbox.
// Addresses are byte addresses as seen by both the FPGA and the CPU side.
package fpga_mailbox_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    READY   = 2'd2,
    DONE    = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE   = 3'd0,
    SEL_OP1    = 3'd1,
    SEL_OP2    = 3'd2,
    SEL_OPSEL  = 3'd3,
    SEL_RESULT = 3'd4,
    SEL_STATUS = 3'd5
  } reg_sel_t;

  localparam logic [31:0] ADDR_OP1      = 32'd220;
  localparam logic [31:0] ADDR_OP2      = 32'd240;
  localparam logic [31:0] ADDR_OPSEL    = 32'd260;
  localparam logic [31:0] ADDR_RESULT   = 32'd280;
  localparam logic [31:0] ADDR_STATUS   = 32'd300;
  localparam logic [31:0] ADDR_UNMAPPED = 32'd320;

  localparam logic [2:0] MASK_FULL = 3'b111;

endpackage

// File: rtl/mbox_addr_dec.sv
// Combinational address decode shared by the FPGA and CPU ports.
module mbox_addr_dec
  import fpga_mailbox_pkg::*;
(
  input  logic [31:0] addr,
  output reg_sel_t    sel
);

  always_comb begin
    // NOTE: default assignment first so no path leaves sel unassigned (no latch).
    sel = SEL_NONE;
    case (addr)
      ADDR_OP1:      sel = SEL_OP1;
      ADDR_OP2:      sel = SEL_OP2;
      ADDR_OPSEL:    sel = SEL_OPSEL;
      ADDR_RESULT:   sel = SEL_RESULT;
      ADDR_STATUS:   sel = SEL_STATUS;
      ADDR_UNMAPPED: sel = SEL_NONE;
      default:       sel = SEL_NONE;
    endcase
  end

endmodule

// File: rtl/fpga_mailbox.sv
// Operand mailbox: the FPGA deposits OP1/OP2/OPSEL, the CPU computes and
// posts RESULT, and the FPGA collects it. nrstFPGA is a synchronous soft clear.
module fpga_mailbox
  import fpga_mailbox_pkg::*;
(
  input  logic        clk,
  input  logic        nrst,
  input  logic        FPGAEnable,
  input  logic        writeFPGA,
  input  logic        nrstFPGA,
  input  logic [31:0] fpga_addr,
  input  logic [31:0] fpga_wdata,
  output logic [31:0] fpga_rdata,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_ack,
  output logic        cpu_start,
  output logic        done
);

  state_t      state, state_next;
  reg_sel_t    fpga_sel, cpu_sel;
  logic [31:0] op1, op2, result;
  logic [4:0]  opsel;
  logic [2:0]  mask;
  logic [31:0] status_word, cpu_read_val, fpga_read_val;
  logic        fpga_wr_ok, fpga_rd, result_wr;

  mbox_addr_dec u_fpga_dec (.addr(fpga_addr), .sel(fpga_sel));
  mbox_addr_dec u_cpu_dec  (.addr(cpu_addr),  .sel(cpu_sel));

  assign status_word = {29'b0, state == DONE, state == READY, state == COLLECT};

  assign fpga_rd    = FPGAEnable & ~writeFPGA;
  assign fpga_wr_ok = FPGAEnable & writeFPGA
                    & ((state == IDLE) | (state == COLLECT))
                    & ((fpga_sel == SEL_OP1) | (fpga_sel == SEL_OP2) | (fpga_sel == SEL_OPSEL));
  assign result_wr  = cpu_write & (state == READY) & (cpu_sel == SEL_RESULT);

  always_comb begin
    cpu_read_val = '0;
    case (cpu_sel)
      SEL_OP1:    cpu_read_val = op1;
      SEL_OP2:    cpu_read_val = op2;
      SEL_OPSEL:  cpu_read_val = {27'b0, opsel};
      SEL_RESULT: cpu_read_val = result;
      SEL_STATUS: cpu_read_val = status_word;
      default:    cpu_read_val = '0;
    endcase
  end

  // The FPGA may only see RESULT once the CPU has posted it.
  always_comb begin
    fpga_read_val = '0;
    case (fpga_sel)
      SEL_RESULT: fpga_read_val = (state == DONE) ? result : '0;
      SEL_STATUS: fpga_read_val = status_word;
      default:    fpga_read_val = '0;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (fpga_wr_ok)         state_next = COLLECT;
      COLLECT: if (mask == MASK_FULL)  state_next = READY;
      READY:   if (result_wr)          state_next = DONE;
      default: state_next = state;
    endcase
  end

  // NOTE: all state here is sequential, so every assignment uses <= to keep
  // reads of op1/result/state returning the pre-edge values.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state      <= IDLE;
      op1        <= '0;
      op2        <= '0;
      opsel      <= '0;
      result     <= '0;
      mask       <= '0;
      fpga_rdata <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_start  <= 1'b0;
      done       <= 1'b0;
    end else if (!nrstFPGA) begin
      state      <= IDLE;
      op1        <= '0;
      op2        <= '0;
      opsel      <= '0;
      result     <= '0;
      mask       <= '0;
      fpga_rdata <= '0;
      cpu_rdata  <= '0;
      cpu_ack    <= 1'b0;
      cpu_start  <= 1'b0;
      done       <= 1'b0;
    end else begin
      state     <= state_next;
      cpu_start <= (state_next == READY);
      done      <= result_wr;
      cpu_ack   <= cpu_read;
      if (cpu_read) cpu_rdata  <= cpu_read_val;
      if (fpga_rd)  fpga_rdata <= fpga_read_val;
      if (result_wr) result <= cpu_wdata;
      if (fpga_wr_ok) begin
        case (fpga_sel)
          SEL_OP1:   begin op1   <= fpga_wdata;      mask[0] <= 1'b1; end
          SEL_OP2:   begin op2   <= fpga_wdata;      mask[1] <= 1'b1; end
          SEL_OPSEL: begin opsel <= fpga_wdata[4:0]; mask[2] <= 1'b1; end
          default:   ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fpga_mailbox.sv
// Self-checking bench for fpga_mailbox: directed vector table, hand-written
// reset corner cases, and random traffic against a behavioural model.
module tb_fpga_mailbox;

  logic        clk = 1'b0;
  logic        nrst;
  logic        FPGAEnable, writeFPGA, nrstFPGA;
  logic [31:0] fpga_addr, fpga_wdata, fpga_rdata;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_ack, cpu_start, done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_mailbox dut (
    .clk(clk), .nrst(nrst),
    .FPGAEnable(FPGAEnable), .writeFPGA(writeFPGA), .nrstFPGA(nrstFPGA),
    .fpga_addr(fpga_addr), .fpga_wdata(fpga_wdata), .fpga_rdata(fpga_rdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .cpu_ack(cpu_ack), .cpu_start(cpu_start), .done(done)
  );

  typedef struct {
    string       name;
    logic        fen, fwr, fnrst;
    logic [31:0] faddr, fwdata;
    logic        crd, cwr;
    logic [31:0] caddr, cwdata;
    logic [31:0] e_frdata;
    logic        e_ack;
    logic [31:0] e_crdata;
    logic        e_start, e_done;
  } vec_t;

  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic vec_t v(input string n,
                             input logic fen, input logic fwr, input logic fn,
                             input logic [31:0] fa, input logic [31:0] fd,
                             input logic crd, input logic cwr,
                             input logic [31:0] ca, input logic [31:0] cd,
                             input logic [31:0] efr, input logic eack,
                             input logic [31:0] ecr, input logic es, input logic ed);
    vec_t r;
    r.name = n; r.fen = fen; r.fwr = fwr; r.fnrst = fn; r.faddr = fa; r.fwdata = fd;
    r.crd = crd; r.cwr = cwr; r.caddr = ca; r.cwdata = cd;
    r.e_frdata = efr; r.e_ack = eack; r.e_crdata = ecr; r.e_start = es; r.e_done = ed;
    return r;
  endfunction

  task automatic set_idle();
    FPGAEnable = 0; writeFPGA = 0; nrstFPGA = 1; fpga_addr = 0; fpga_wdata = 0;
    cpu_read = 0; cpu_write = 0; cpu_addr = 0; cpu_wdata = 0;
  endtask

  task automatic fpga_write(input logic [31:0] a, input logic [31:0] d);
    set_idle();
    FPGAEnable = 1; writeFPGA = 1; fpga_addr = a; fpga_wdata = d;
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_frdata"}, fpga_rdata, 0);
    check({tag, "_crdata"}, cpu_rdata, 0);
    check({tag, "_ack"}, {31'b0, cpu_ack}, 0);
    check({tag, "_start"}, {31'b0, cpu_start}, 0);
    check({tag, "_done"}, {31'b0, done}, 0);
  endtask

  // Behavioural model: operands, a written-set, and three phase flags.
  logic [31:0] m_op[3];
  bit          m_w[3];
  logic [31:0] m_result;
  bit          m_coll, m_ready, m_have;
  logic [31:0] e_fr, e_cr;
  bit          e_ack, e_start, e_done;

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin m_op[i] = 0; m_w[i] = 0; end
    m_result = 0; m_coll = 0; m_ready = 0; m_have = 0;
    e_fr = 0; e_cr = 0; e_ack = 0; e_start = 0; e_done = 0;
  endtask

  function automatic logic [31:0] m_status();
    return {29'b0, m_have, m_ready, m_coll};
  endfunction

  function automatic int op_index(input logic [31:0] a);
    if (a == 220) return 0;
    if (a == 240) return 1;
    if (a == 260) return 2;
    return -1;
  endfunction

  task automatic model_step();
    bit old_ready, old_have, old_coll, all_w;
    int idx;
    if (!nrstFPGA) begin model_clear(); return; end
    old_ready = m_ready; old_have = m_have; old_coll = m_coll;
    all_w = m_w[0] && m_w[1] && m_w[2];
    e_done = 0;
    e_ack  = cpu_read;
    if (cpu_read) begin
      idx = op_index(cpu_addr);
      if (idx >= 0)            e_cr = m_op[idx];
      else if (cpu_addr == 280) e_cr = m_result;
      else if (cpu_addr == 300) e_cr = m_status();
      else                      e_cr = 0;
    end
    if (FPGAEnable && !writeFPGA) begin
      if (fpga_addr == 280)      e_fr = m_have ? m_result : 0;
      else if (fpga_addr == 300) e_fr = m_status();
      else                       e_fr = 0;
    end
    idx = op_index(fpga_addr);
    if (FPGAEnable && writeFPGA && !old_ready && !old_have && idx >= 0) begin
      m_op[idx] = (idx == 2) ? {27'b0, fpga_wdata[4:0]} : fpga_wdata;
      m_w[idx]  = 1;
      m_coll    = 1;
    end
    if (old_ready && cpu_write && cpu_addr == 280) begin
      m_result = cpu_wdata; e_done = 1; m_ready = 0; m_have = 1;
    end else if (old_coll && all_w) begin
      m_coll = 0; m_ready = 1;
    end
    e_start = m_ready;
  endtask

  logic [31:0] addr_pool[7];

  initial begin
    addr_pool = '{32'd220, 32'd240, 32'd260, 32'd280, 32'd300, 32'd320, 32'd500};
    //                name            fen fwr fn  faddr fwdata  crd cwr caddr cwdata  efr  ack ecr   st dn
    vecs[0]  = v("wr_op1",          1, 1, 1, 220, 32'h12,  0, 0, 0,   0,      0,   0, 0,     0, 0);
    vecs[1]  = v("wr_op2",          1, 1, 1, 240, 32'h34,  0, 0, 0,   0,      0,   0, 0,     0, 0);
    vecs[2]  = v("wr_opsel",        1, 1, 1, 260, 32'h1F,  0, 0, 0,   0,      0,   0, 0,     0, 0);
    vecs[3]  = v("status_collect",  1, 0, 1, 300, 0,       0, 0, 0,   0,      1,   0, 0,     1, 0);
    vecs[4]  = v("ready_rd_op2",    1, 0, 1, 300, 0,       1, 0, 240, 0,      2,   1, 32'h34,1, 0);
    vecs[5]  = v("rd_unmapped",     1, 1, 1, 220, 32'h99,  1, 0, 500, 0,      2,   1, 0,     1, 0);
    vecs[6]  = v("op1_kept",        0, 0, 1, 0,   0,       1, 0, 220, 0,      2,   1, 32'h12,1, 0);
    vecs[7]  = v("wr_result",       0, 0, 1, 0,   0,       0, 1, 280, 32'h46, 2,   0, 0,     0, 1);
    vecs[8]  = v("fpga_rd_result",  1, 0, 1, 280, 0,       0, 0, 0,   0,      32'h46, 0, 0,  0, 0);
    vecs[9]  = v("status_done",     1, 0, 1, 300, 0,       1, 0, 280, 0,      4,   1, 32'h46,0, 0);
    vecs[10] = v("soft_clear",      1, 0, 0, 300, 0,       1, 0, 280, 0,      0,   0, 0,     0, 0);
    vecs[11] = v("wr_op1_b",        1, 1, 1, 220, 5,       0, 0, 0,   0,      0,   0, 0,     0, 0);
    vecs[12] = v("wr_op2_b",        1, 1, 1, 240, 6,       0, 0, 0,   0,      0,   0, 0,     0, 0);
    vecs[13] = v("wr_opsel_b",      1, 1, 1, 260, 7,       0, 0, 0,   0,      0,   0, 0,     0, 0);
    vecs[14] = v("ready_b",         0, 0, 1, 0,   0,       0, 0, 0,   0,      0,   0, 0,     1, 0);
    vecs[15] = v("clear_vs_result", 0, 0, 0, 0,   0,       1, 1, 280, 32'h77, 0,   0, 0,     0, 0);
    vecs[16] = v("after_clear",     1, 0, 1, 300, 0,       1, 0, 280, 0,      0,   1, 0,     0, 0);

    set_idle();
    nrst = 0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    nrst = 1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      FPGAEnable = vecs[i].fen;  writeFPGA = vecs[i].fwr; nrstFPGA = vecs[i].fnrst;
      fpga_addr  = vecs[i].faddr; fpga_wdata = vecs[i].fwdata;
      cpu_read   = vecs[i].crd;  cpu_write = vecs[i].cwr;
      cpu_addr   = vecs[i].caddr; cpu_wdata = vecs[i].cwdata;
      @(negedge clk);
      check({vecs[i].name, "_frdata"}, fpga_rdata, vecs[i].e_frdata);
      check({vecs[i].name, "_ack"}, {31'b0, cpu_ack}, {31'b0, vecs[i].e_ack});
      if (vecs[i].e_ack) check({vecs[i].name, "_crdata"}, cpu_rdata, vecs[i].e_crdata);
      check({vecs[i].name, "_start"}, {31'b0, cpu_start}, {31'b0, vecs[i].e_start});
      check({vecs[i].name, "_done"}, {31'b0, done}, {31'b0, vecs[i].e_done});
    end

    // Hard reset lands between a CPU request and its ack, with a result write pending.
    fpga_write(220, 32'hA);
    fpga_write(240, 32'hB);
    fpga_write(260, 32'hC);
    set_idle();
    @(negedge clk);
    check("pre_reset_start", {31'b0, cpu_start}, 1);
    cpu_read = 1; cpu_addr = 220; cpu_write = 1; cpu_wdata = 32'h55;
    #2 nrst = 0;
    @(posedge clk);
    #1 check_all_zero("midreset");
    @(negedge clk);
    set_idle();
    nrst = 1;
    @(negedge clk);
    check("post_reset_ack", {31'b0, cpu_ack}, 0);
    check("post_reset_done", {31'b0, done}, 0);

    // Random traffic against the model.
    model_clear();
    for (int n = 0; n < 600; n++) begin
      FPGAEnable = ($urandom_range(0, 3) != 0);
      writeFPGA  = ($urandom_range(0, 1) == 1);
      nrstFPGA   = ($urandom_range(0, 49) != 0);
      fpga_addr  = ($urandom_range(0, 9) == 0) ? $urandom : addr_pool[$urandom_range(0, 6)];
      fpga_wdata = $urandom;
      cpu_read   = ($urandom_range(0, 2) == 0);
      cpu_write  = ($urandom_range(0, 2) == 0);
      cpu_addr   = ($urandom_range(0, 9) == 0) ? $urandom : addr_pool[$urandom_range(0, 6)];
      cpu_wdata  = $urandom;
      model_step();
      @(negedge clk);
      check("rnd_frdata", fpga_rdata, e_fr);
      check("rnd_ack", {31'b0, cpu_ack}, {31'b0, e_ack});
      if (e_ack) check("rnd_crdata", cpu_rdata, e_cr);
      check("rnd_start", {31'b0, cpu_start}, {31'b0, e_start});
      check("rnd_done", {31'b0, done}, {31'b0, e_done});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpga_mailbox.md
FPGA_MAILBOX -- requirements
Module: fpga_mailbox

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port nrst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port FPGAEnable, input, 1: FPGA-side access request.
REQ-004 SHALL have port writeFPGA, input, 1: FPGA-side write when FPGAEnable=1.
REQ-005 SHALL have port nrstFPGA, input, 1: active-low synchronous soft clear from the FPGA side.
REQ-006 SHALL have port fpga_addr, input, 32: FPGA-side byte address.
REQ-007 SHALL have port fpga_wdata, input, 32: FPGA-side write data.
REQ-008 SHALL have port fpga_rdata, output, 32: FPGA-side read data, registered.
REQ-009 SHALL have ports cpu_read and cpu_write, input, 1 each: CPU-side access strobes, one cycle each.
REQ-010 SHALL have port cpu_addr, input, 32, and port cpu_wdata, input, 32.
REQ-011 SHALL have port cpu_rdata, output, 32, and port cpu_ack, output, 1: registered read data and completion pulse.
REQ-012 SHALL have port cpu_start, output, 1: high while operands are ready for the CPU.
REQ-013 SHALL have port done, output, 1: single-cycle pulse when a result is latched.

Function
REQ-014 SHALL decode addresses 220=OP1, 240=OP2, 260=OPSEL, 280=RESULT, 300=STATUS; 320 and all other addresses are unmapped.
REQ-015 SHALL implement the states IDLE, COLLECT, READY, DONE.
REQ-016 SHALL accept an FPGA write (FPGAEnable & writeFPGA) to OP1/OP2/OPSEL only in IDLE or COLLECT, storing OP1/OP2 as 32 bits and OPSEL as fpga_wdata[4:0] zero-extended.
REQ-017 SHALL set a written-mask bit per accepted operand write; a repeated write to the same operand overwrites its value without error.
REQ-018 SHALL move IDLE->COLLECT on the first accepted write, and COLLECT->READY on the cycle after the mask reaches 3'b111.
REQ-019 SHALL assert cpu_start only in READY.
REQ-020 SHALL, in READY, latch a CPU write to RESULT (full 32 bits), pulse done one cycle later, and enter DONE.
REQ-021 SHALL ignore CPU writes in every state except READY, and SHALL ignore CPU writes to OP1/OP2/OPSEL/STATUS.
REQ-022 SHALL ignore FPGA writes in READY and DONE.
REQ-023 SHALL return CPU read data with a latency of one cycle, with cpu_ack high in that same cycle; a read of an unmapped address returns 0 with cpu_ack still high.
REQ-024 SHALL return STATUS as {29'b0, result_valid, ready, collecting}.
REQ-025 SHALL, on an FPGA read (FPGAEnable & !writeFPGA), update fpga_rdata the next cycle: RESULT only in DONE, else 0; STATUS at all times; other mapped addresses return 0.
REQ-026 SHALL, when nrstFPGA=0 in any state, clear all registers, the mask and the flags and go to IDLE on the next edge, taking priority over every simultaneous access.
REQ-027 SHALL allow a simultaneous FPGA access and CPU access in the same cycle, each with its own rules.
REQ-028 SHALL, if cpu_read and cpu_write are both high, perform the write and the read, with the read returning the pre-write value.

Reset
REQ-029 SHALL, on nrst low, asynchronously set state=IDLE, all registers and the mask to 0, and fpga_rdata, cpu_rdata, cpu_ack, cpu_start and done to 0.
REQ-030 SHALL, when reset is asserted mid-transaction, discard any pending read and any pending done pulse.

Structure
REQ-031 SHALL place the state enum and the address constants (220/240/260/280/300/320) in a shared package fpga_mailbox_pkg.
REQ-032 SHALL use one sub-module, mbox_addr_dec, for the combinational address decode, instantiated once for each side.

Verification
REQ-033 SHALL test: FPGA writes OP1=0x12, OP2=0x34, OPSEL=0x1F at 220/240/260 -> READY with cpu_start=1 two cycles after the last write; STATUS reads 0x2.
REQ-034 SHALL test: in READY, a CPU read at 240 -> cpu_rdata=0x34 with cpu_ack=1 exactly one cycle later; a read at 500 -> 0 with cpu_ack=1.
REQ-035 SHALL test: a CPU write of 0x46 to 280 in READY -> done pulses for one cycle, state DONE, and an FPGA read at 280 returns 0x46.
REQ-036 SHALL test: an FPGA write of OP1=0x99 in READY -> ignored, and a CPU read at 220 still returns 0x12.
REQ-037 SHALL test: nrstFPGA=0 in the same cycle as a CPU write to 280 -> IDLE, RESULT=0 and no done pulse.
REQ-038 SHALL test: nrst asserted between a CPU read request and its ack -> cpu_ack stays 0 and all outputs are 0.
